// File: rtl/mod_inv_q.sv
// mod_inv_q: sequential modular inverter, z = a^-1 mod Q (binary extended Euclid).
// Ports: clk, rst_n (async, active low); in_valid/in_ready/a operand side;
//        out_valid/out_ready/z/err result side.
// Build option MOD_INV_Q_CYCLE_CNT_EN adds output cycles[6:0], the ITER count
// of the current result (assumes MAX_CYCLES <= 127 when enabled).
module mod_inv_q #(
    parameter int WIDTH      = 23,
    parameter int Q          = 8380417,
    parameter int MAX_CYCLES = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             err
`ifdef MOD_INV_Q_CYCLE_CNT_EN
    ,
    output logic [6:0]       cycles
`endif
);

`ifdef MOD_INV_Q_CYCLE_CNT_EN
    localparam int CW = 7;
`else
    localparam int CW = $clog2(MAX_CYCLES + 1);
`endif

    localparam logic [WIDTH-1:0] QW  = WIDTH'(Q);
    localparam logic [WIDTH-1:0] QH1 = WIDTH'((Q >> 1) + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [CW-1:0]    CMX = CW'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_u;
    logic [WIDTH-1:0] r_v;
    logic [WIDTH-1:0] r_x1;
    logic [WIDTH-1:0] r_x2;
    logic [WIDTH-1:0] r_z;
    logic             r_err;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_red;
    logic [WIDTH-1:0] w_x1_half;
    logic [WIDTH-1:0] w_x2_half;
    logic [WIDTH-1:0] w_x1_sub;
    logic [WIDTH-1:0] w_x2_sub;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_cnt_hit;

    // a < 2^WIDTH < 2Q, so one conditional subtraction fully reduces it.
    assign w_red = (r_a >= QW) ? r_a - QW : r_a;

    // Halving mod Q: for odd x, (x+Q)/2 = (x>>1) + (Q>>1) + 1, which keeps
    // the arithmetic within WIDTH bits without a widened sum.
    assign w_x1_half = r_x1[0] ? {1'b0, r_x1[WIDTH-1:1]} + QH1
                               : {1'b0, r_x1[WIDTH-1:1]};
    assign w_x2_half = r_x2[0] ? {1'b0, r_x2[WIDTH-1:1]} + QH1
                               : {1'b0, r_x2[WIDTH-1:1]};

    // Modular subtraction; the wrapped difference plus Q lands in [1,Q).
    assign w_x1_sub = (r_x1 >= r_x2) ? r_x1 - r_x2 : r_x1 - r_x2 + QW;
    assign w_x2_sub = (r_x2 >= r_x1) ? r_x2 - r_x1 : r_x2 - r_x1 + QW;

`ifdef MOD_INV_Q_CYCLE_CNT_EN
    assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign cycles    = r_cnt;
`else
    assign w_cnt_nxt = r_cnt + 1'b1;
`endif
    assign w_cnt_hit = (w_cnt_nxt >= CMX);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign z         = r_z;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_u         <= '0;
            r_v         <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_z         <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_in_ready <= 1'b0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt <= '0;
                    if (w_red == '0) begin
                        r_z         <= '0;
                        r_err       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_u     <= w_red;
                        r_v     <= QW;
                        r_x1    <= ONE;
                        r_x2    <= '0;
                        r_err   <= 1'b0;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_cnt <= w_cnt_nxt;
                    if (r_u == ONE) begin
                        r_z         <= r_x1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_v == ONE) begin
                        r_z         <= r_x2;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_cnt_hit) begin
                        r_z         <= '0;
                        r_err       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (!r_u[0]) begin
                        r_u  <= r_u >> 1;
                        r_x1 <= w_x1_half;
                    end else if (!r_v[0]) begin
                        r_v  <= r_v >> 1;
                        r_x2 <= w_x2_half;
                    end else if (r_u >= r_v) begin
                        r_u  <= r_u - r_v;
                        r_x1 <= w_x1_sub;
                    end else begin
                        r_v  <= r_v - r_u;
                        r_x2 <= w_x2_sub;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
